// File: rtl/adder_arbiter.sv
// Round-robin arbiter that time-shares one external sequential adder among NREQ requesters.
// Optional ADDER_ARBITER_STATS_EN adds per-requester saturating completion counters (op_count_o).
module adder_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int ADD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*WIDTH-1:0]   in1_i,
  input  logic [NREQ*WIDTH-1:0]   in2_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [NREQ-1:0]         done_o,
  output logic [WIDTH:0]          result_o,
  output logic                    add_en_o,
  output logic [WIDTH-1:0]        add_in1_o,
  output logic [WIDTH-1:0]        add_in2_o,
  input  logic [WIDTH:0]          add_sum_i
`ifdef ADDER_ARBITER_STATS_EN
  ,
  output logic [NREQ*16-1:0]      op_count_o
`endif
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [IDXW:0]   NREQ_W   = (IDXW+1)'(NREQ);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'((ADD_LAT > 0) ? ADD_LAT - 1 : 0);

  if (ADD_LAT < 1) begin : g_bad_add_lat
    $error("adder_arbiter: ADD_LAT must be at least 1");
  end
  if ((NREQ < 2) || (NREQ > 8)) begin : g_bad_nreq
    $error("adder_arbiter: NREQ must be in 2..8");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_r;
  logic [IDXW-1:0]   rr_r;
  logic [IDXW-1:0]   idx_r;
  logic [CNTW-1:0]   wait_cnt_r;
  logic              win_found_s;
  logic [IDXW-1:0]   win_idx_s;
  logic [IDXW:0]     cand_s;

  function automatic logic [IDXW-1:0] wrap_idx(input logic [IDXW:0] v);
    logic [IDXW:0] t;
    if (v >= NREQ_W) begin
      t = v - NREQ_W;
    end else begin
      t = v;
    end
    return t[IDXW-1:0];
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] i);
    return {{(NREQ-1){1'b0}}, 1'b1} << i;
  endfunction

  // Round-robin pick: scan from rr upward with wrap; descending loop lets the nearest hit win.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand_s = {1'b0, rr_r} + (IDXW+1)'(i);
      if (req_i[wrap_idx(cand_s)]) begin
        win_found_s = 1'b1;
        win_idx_s   = wrap_idx(cand_s);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      rr_r       <= '0;
      idx_r      <= '0;
      wait_cnt_r <= '0;
      gnt_o      <= '0;
      done_o     <= '0;
      result_o   <= '0;
      add_en_o   <= 1'b0;
      add_in1_o  <= '0;
      add_in2_o  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (win_found_s) begin
            idx_r     <= win_idx_s;
            add_in1_o <= in1_i[win_idx_s*WIDTH +: WIDTH];
            add_in2_o <= in2_i[win_idx_s*WIDTH +: WIDTH];
            add_en_o  <= 1'b1;
            gnt_o     <= onehot(win_idx_s);
            state_r   <= ISSUE;
          end else begin
            state_r   <= IDLE;
          end
        end
        ISSUE: begin
          add_en_o   <= 1'b0;
          wait_cnt_r <= '0;
          state_r    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt_r == CNT_LAST) begin
            result_o <= add_sum_i;
            done_o   <= onehot(idx_r);
            state_r  <= RESP;
          end else begin
            wait_cnt_r <= wait_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
          end
        end
        RESP: begin
          done_o  <= '0;
          gnt_o   <= '0;
          rr_r    <= wrap_idx({1'b0, idx_r} + {{IDXW{1'b0}}, 1'b1});
          state_r <= IDLE;
        end
        default: begin
          state_r  <= IDLE;
          gnt_o    <= '0;
          done_o   <= '0;
          add_en_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef ADDER_ARBITER_STATS_EN
  // Saturating per-requester completion counters, bumped on each RESP cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_count_o <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if ((state_r == RESP) && (idx_r == IDXW'(k)) &&
            (op_count_o[k*16 +: 16] != 16'hFFFF)) begin
          op_count_o[k*16 +: 16] <= op_count_o[k*16 +: 16] + 16'd1;
        end else begin
          op_count_o[k*16 +: 16] <= op_count_o[k*16 +: 16];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter (NREQ=4, WIDTH=8, ADD_LAT=1) with a one-cycle adder model.
module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_i;
  logic [31:0] in1_i;
  logic [31:0] in2_i;
  logic [3:0]  gnt_o;
  logic [3:0]  done_o;
  logic [8:0]  result_o;
  logic        add_en_o;
  logic [7:0]  add_in1_o;
  logic [7:0]  add_in2_o;
  logic [8:0]  add_sum_r = 9'h000;
`ifdef ADDER_ARBITER_STATS_EN
  logic [63:0] op_count_o;
`endif

  int checks   = 0;
  int failures = 0;
  logic [8:0] exp_res [4] = '{9'h011, 9'h022, 9'h033, 9'h100};

  adder_arbiter #(.NREQ(4), .WIDTH(8), .ADD_LAT(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req_i),
    .in1_i     (in1_i),
    .in2_i     (in2_i),
    .gnt_o     (gnt_o),
    .done_o    (done_o),
    .result_o  (result_o),
    .add_en_o  (add_en_o),
    .add_in1_o (add_in1_o),
    .add_in2_o (add_in2_o),
    .add_sum_i (add_sum_r)
`ifdef ADDER_ARBITER_STATS_EN
    ,
    .op_count_o(op_count_o)
`endif
  );

  always #5 clk = ~clk;

  // Shared sequential adder with one cycle of latency.
  always_ff @(posedge clk) begin
    if (add_en_o) begin
      add_sum_r <= {1'b0, add_in1_o} + {1'b0, add_in2_o};
    end else begin
      add_sum_r <= add_sum_r;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 16 cycles starting from an IDLE negedge; idxs holds four 2-bit served indices, oldest in [1:0].
  task automatic run_window(input string tag, input logic [7:0] idxs);
    logic [1:0] k;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      check_eq({tag, "_onehot"}, {31'd0, $onehot0(gnt_o)}, 32'd1);
      if ((c % 4) == 3) begin
        k = idxs[((c - 3) / 4) * 2 +: 2];
        check_eq({tag, "_done"}, {28'd0, done_o}, {28'd0, 4'b0001 << k});
        check_eq({tag, "_result"}, {23'd0, result_o}, {23'd0, exp_res[k]});
      end else begin
        check_eq({tag, "_done_idle"}, {28'd0, done_o}, 32'd0);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_gnt"}, {28'd0, gnt_o}, 32'd0);
    check_eq({tag, "_done"}, {28'd0, done_o}, 32'd0);
    check_eq({tag, "_add_en"}, {31'd0, add_en_o}, 32'd0);
    check_eq({tag, "_add_in1"}, {24'd0, add_in1_o}, 32'd0);
    check_eq({tag, "_add_in2"}, {24'd0, add_in2_o}, 32'd0);
    check_eq({tag, "_result"}, {23'd0, result_o}, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    req_i = 4'b0000;
    in1_i = 32'd0;
    in2_i = 32'd0;
    @(negedge clk);
    check_all_zero("reset");

    // 05 + 0A on requester 0; inputs scrambled right after issue
    reset = 1'b1;
    req_i = 4'b0001;
    in1_i = 32'h0000_0005;
    in2_i = 32'h0000_000A;
    @(negedge clk);
    check_eq("op1_add_en", {31'd0, add_en_o}, 32'd1);
    check_eq("op1_in1", {24'd0, add_in1_o}, 32'h05);
    check_eq("op1_in2", {24'd0, add_in2_o}, 32'h0A);
    check_eq("op1_gnt_issue", {28'd0, gnt_o}, 32'h1);
    req_i = 4'b0000;
    in1_i = 32'h0000_00EE;
    @(negedge clk);
    check_eq("op1_add_en_wait", {31'd0, add_en_o}, 32'd0);
    check_eq("op1_gnt_wait", {28'd0, gnt_o}, 32'h1);
    check_eq("op1_done_wait", {28'd0, done_o}, 32'd0);
    @(negedge clk);
    check_eq("op1_done", {28'd0, done_o}, 32'h1);
    check_eq("op1_result", {23'd0, result_o}, 32'h00F);
    check_eq("op1_gnt_resp", {28'd0, gnt_o}, 32'h1);
    @(negedge clk);
    check_eq("op1_done_after", {28'd0, done_o}, 32'd0);
    check_eq("op1_gnt_after", {28'd0, gnt_o}, 32'd0);
    check_eq("op1_in1_hold", {24'd0, add_in1_o}, 32'h05);

    // FF + 01 carry-out; rr=1 but only requester 0 asks
    req_i = 4'b0001;
    in1_i = 32'h0000_00FF;
    in2_i = 32'h0000_0001;
    @(negedge clk);
    check_eq("op2_in1", {24'd0, add_in1_o}, 32'hFF);
    req_i = 4'b0000;
    in2_i = 32'h0000_0055;
    @(negedge clk);
    @(negedge clk);
    check_eq("op2_done", {28'd0, done_o}, 32'h1);
    check_eq("op2_result", {23'd0, result_o}, 32'h100);
    @(negedge clk);

    // All four requesting from reset release
    reset = 1'b0;
    #1;
    check_all_zero("reset2");
    @(negedge clk);
    reset = 1'b1;
    req_i = 4'b1111;
    in1_i = 32'h40_30_20_10;
    in2_i = 32'hC0_03_02_01;
    run_window("rr_all", {2'd3, 2'd2, 2'd1, 2'd0});

    // Two requesters alternate
    req_i = 4'b0101;
    run_window("rr_0101", {2'd2, 2'd0, 2'd2, 2'd0});

    // Reset during WAIT for requester 1 (rr=3 here)
    req_i = 4'b0010;
    @(negedge clk);
    check_eq("r1_gnt_issue", {28'd0, gnt_o}, 32'h2);
    @(negedge clk);
    check_eq("r1_add_en_wait", {31'd0, add_en_o}, 32'd0);
    reset = 1'b0;
    #1;
    check_all_zero("reset_wait");
    req_i = 4'b0000;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq("no_stale_done", {28'd0, done_o}, 32'd0);
      check_eq("no_stale_gnt", {28'd0, gnt_o}, 32'd0);
    end
    req_i = 4'b1010;
    run_window("rr_after_reset", {2'd3, 2'd1, 2'd3, 2'd1});

`ifdef ADDER_ARBITER_STATS_EN
    reset = 1'b0;
    #1;
    check_eq("stats_reset", op_count_o[31:0], 32'd0);
    @(negedge clk);
    reset = 1'b1;
    req_i = 4'b0100;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
    end
    req_i = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
    end
    check_eq("stats_req2", {16'd0, op_count_o[47:32]}, 32'd3);
    check_eq("stats_others_lo", op_count_o[31:0], 32'd0);
    check_eq("stats_other3", {16'd0, op_count_o[63:48]}, 32'd0);
    reset = 1'b0;
    #1;
    check_eq("stats_clear", {16'd0, op_count_o[47:32]}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters; legal range 2..8.
REQ-002 Parameter WIDTH, default 8, operand width.
REQ-003 Parameter ADD_LAT, default 1, cycles from add_en_o sampled to add_sum_i valid; ADD_LAT < 1 SHALL be an elaboration error.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 req_i  input  NREQ  per-requester request level.
REQ-007 in1_i  input  NREQ*WIDTH  operand A; requester k in bits [k*WIDTH +: WIDTH].
REQ-008 in2_i  input  NREQ*WIDTH  operand B, same packing.
REQ-009 gnt_o  output  NREQ  one-hot grant; at most one bit set.
REQ-010 done_o  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-011 result_o  output  WIDTH+1  sum; valid only while any done_o bit is 1.
REQ-012 add_en_o  output  1  enable to shared sequential adder.
REQ-013 add_in1_o / add_in2_o  output  WIDTH each  adder operands.
REQ-014 add_sum_i  input  WIDTH+1  adder result.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-016 IDLE: if any req_i bit is 1, select winner by round-robin starting at pointer rr, latch winner index and its operands into add_in1_o/add_in2_o, go ISSUE; else stay IDLE.
REQ-017 ISSUE (1 cycle): add_en_o = 1, gnt_o[idx] = 1; next state WAIT.
REQ-018 WAIT (exactly ADD_LAT cycles): add_en_o = 0; on the last WAIT cycle capture add_sum_i into result_o; next state RESP.
REQ-019 RESP (1 cycle): done_o[idx] = 1, result_o held; rr <= (idx+1) mod NREQ; next state IDLE.
REQ-020 gnt_o[idx] SHALL be 1 from ISSUE through RESP inclusive, 0 in IDLE.
REQ-021 Latency: req sampled in IDLE cycle 0 -> done_o in cycle ADD_LAT+2; throughput one operation per ADD_LAT+3 cycles.
REQ-022 Operands are latched at IDLE exit; later changes on in1_i/in2_i or a dropped req_i do not affect the operation, and done_o still pulses.
REQ-023 A requester holding req_i through RESP is re-eligible in the next IDLE but ranks behind all others per rr.
REQ-024 add_in1_o/add_in2_o hold their last values outside ISSUE; no arithmetic is performed in this block.

Reset
REQ-025 reset = 0 SHALL immediately force state IDLE, gnt_o = 0, done_o = 0, add_en_o = 0, add_in1_o = 0, add_in2_o = 0, result_o = 0, rr = 0.
REQ-026 Reset during ISSUE/WAIT/RESP discards the operation; no done_o pulse is produced for it after release.
REQ-027 First arbitration after reset release occurs on the first rising edge with reset = 1.

Configuration
REQ-028 Macro ADDER_ARBITER_STATS_EN: when defined, adds output op_count_o (NREQ*16), per-requester count of done_o pulses, saturating at 16'hFFFF, cleared by reset.
REQ-029 Without ADDER_ARBITER_STATS_EN, op_count_o and its counters SHALL be absent; all other behaviour identical.

Verification (NREQ=4, WIDTH=8, ADD_LAT=1, sequential adder attached)
REQ-030 req_i=4'b0001, in1=8'h05, in2=8'h0A -> add_en_o 1 for one cycle with 05/0A; done_o=4'b0001 at cycle 3; result_o=9'h00F.
REQ-031 req0 with 8'hFF + 8'h01 -> result_o=9'h100.
REQ-032 req_i=4'b1111 held from reset release -> done_o order 0,1,2,3, each 4 cycles apart, gnt_o always one-hot.
REQ-033 req_i=4'b0101 held continuously -> service alternates 0,2,0,2.
REQ-034 reset=0 asserted during WAIT for req1 -> all outputs 0 at once; no done_o[1]; next grant after release follows rr=0.
REQ-035 ADDER_ARBITER_STATS_EN defined, 3 ops on req2 -> op_count_o[2*16 +: 16]=3, other fields 0; reset clears to 0.
